// File: rtl/freq_meter_pkg.sv
// Shared types and default sizing for the frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMeasure = 2'd1,
    StDone    = 2'd2
  } state_e;

  localparam int unsigned GateCyclesDefault = 125000;
  localparam int unsigned CntWDefault       = 32;

endpackage

// File: rtl/edge_sync.sv
// Rising-edge detector for sig_in; FREQ_METER_SYNC_EN adds a 2-flop synchronizer in front.
module edge_sync (
  input  logic clk_in,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

`ifdef FREQ_METER_SYNC_EN
  logic [1:0] sync_q;
  logic       hist_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sig_in};
      hist_q <= sync_q[1];
    end
  end

  assign rise = sync_q[1] & ~hist_q;
`else
  logic hist_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= sig_in;
    end
  end

  // sig_in is already synchronous to clk_in, so compare it directly with its history.
  assign rise = sig_in & ~hist_q;
`endif

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts sig_in rises over GATE_CYCLES clocks, one-shot or continuous.
// Optional input synchronizer selected by macro FREQ_METER_SYNC_EN.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 125000000,
  parameter int unsigned GATE_CYCLES = GateCyclesDefault,
  parameter int unsigned CNT_W       = CntWDefault
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             ovf
);

  localparam int unsigned GateW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EdgeMax  = {CNT_W{1'b1}};

  if (GATE_CYCLES < 2 || CLK_HZ == 0) begin : g_param_check
    $error("freq_meter: GATE_CYCLES must be >= 2 and CLK_HZ non-zero");
  end

  state_e             state_q, state_d;
  logic [GateW-1:0]   gate_q, gate_d;
  logic [CNT_W-1:0]   edge_q, edge_d;
  logic               sat_q, sat_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               rise;

  edge_sync u_edge_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise   (rise)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gate_q  <= '0;
      edge_q  <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      edge_q  <= edge_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    edge_d  = edge_q;
    sat_d   = sat_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StMeasure;
          gate_d  = '0;
          edge_d  = '0;
          sat_d   = 1'b0;
        end
      end
      StMeasure: begin
        if (rise) begin
          if (edge_q == EdgeMax) begin
            sat_d = 1'b1;
          end else begin
            edge_d = edge_q + CNT_W'(1);
          end
        end
        if (gate_q == GateLast) begin
          state_d = StDone;
        end else begin
          gate_d = gate_q + GateW'(1);
        end
      end
      StDone: begin
        count_d = edge_q;
        ovf_d   = sat_q;
        // Edges arriving in this cycle are dropped: the next window starts clean.
        if (cont) begin
          state_d = StMeasure;
          gate_d  = '0;
          edge_d  = '0;
          sat_d   = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Present the fresh result during the valid cycle itself, not one cycle later.
  assign count = (state_q == StDone) ? edge_q : count_q;
  assign ovf   = (state_q == StDone) ? sat_q  : ovf_q;
  assign valid = (state_q == StDone);
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 32-bit instance and a 4-bit overflow instance share stimulus.
module tb_freq_meter;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       sig_in;
  logic       start;
  logic       cont;
  logic       busy, valid, ovf;
  logic [31:0] count;
  logic       busy4, valid4, ovf4;
  logic [3:0] count4;

  int n_vec  = 0;
  int n_miss = 0;

  int period    = 10;
  int sig_level = 0;
  int phase     = 0;

`ifdef FREQ_METER_SYNC_EN
  localparam int ExpLatency = 3;
`else
  localparam int ExpLatency = 1;
`endif

  always #5 clk_in = ~clk_in;

  freq_meter #(
    .GATE_CYCLES (100),
    .CNT_W       (32)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .start  (start),
    .cont   (cont),
    .busy   (busy),
    .count  (count),
    .valid  (valid),
    .ovf    (ovf)
  );

  freq_meter #(
    .GATE_CYCLES (100),
    .CNT_W       (4)
  ) dut4 (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .start  (start),
    .cont   (cont),
    .busy   (busy4),
    .count  (count4),
    .valid  (valid4),
    .ovf    (ovf4)
  );

  // Periodic sig_in with half-period high; period 0 holds sig_level.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      if (period == 0) begin
        sig_in = (sig_level != 0);
      end else begin
        sig_in = (phase < period / 2);
        phase  = (phase + 1 >= period) ? 0 : phase + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One-shot window on both instances; optional stray start pulse mid-window.
  task automatic one_shot(input string tag, input int exp_cnt, input int exp_ovf,
                          input int exp_cnt4, input int exp_ovf4, input int stray_at);
    int busy_cyc = 0;
    int valids   = 0;
    int valids4  = 0;
    int cap      = -1;
    int capo     = -1;
    int cap4     = -1;
    int capo4    = -1;
    @(posedge clk_in);
    #1 start = 1'b1;
    @(posedge clk_in);
    #1 start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_in);
      start = (i == stray_at);
      if (busy) busy_cyc++;
      if (valid) begin
        valids++;
        cap  = int'(count);
        capo = int'(ovf);
      end
      if (valid4) begin
        valids4++;
        cap4  = int'(count4);
        capo4 = int'(ovf4);
      end
      if (!busy && busy_cyc > 0) break;
    end
    start = 1'b0;
    check_eq({tag, ".busy_cycles"}, busy_cyc, 101);
    check_eq({tag, ".valid_pulses"}, valids, 1);
    check_eq({tag, ".count"}, cap, exp_cnt);
    check_eq({tag, ".ovf"}, capo, exp_ovf);
    check_eq({tag, ".valid4_pulses"}, valids4, 1);
    check_eq({tag, ".count4"}, cap4, exp_cnt4);
    check_eq({tag, ".ovf4"}, capo4, exp_ovf4);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
  endtask

  initial begin
    int lat;
    int n;
    int drops;
    int valids;

    // Reset while sig_in toggles and start is held.
    rst_n = 1'b0;
    start = 1'b1;
    cont  = 1'b0;
    idle(10);
    @(negedge clk_in);
    check_eq("reset.busy", int'(busy), 0);
    check_eq("reset.valid", int'(valid), 0);
    check_eq("reset.count", int'(count), 0);
    check_eq("reset.ovf", int'(ovf), 0);
    check_eq("reset.count4", int'(count4), 0);
    rst_n = 1'b1;
    @(negedge clk_in);
    check_eq("reset.first_edge_start", int'(busy), 1);
    start = 1'b0;
    for (int i = 0; i < 300 && busy; i++) @(negedge clk_in);
    check_eq("reset.drain", int'(busy), 0);

    // Edge-pulse latency through the detector.
    period    = 0;
    sig_level = 0;
    idle(8);
    @(negedge clk_in);
    sig_level = 1;
    @(posedge clk_in);
    #2;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_in);
      if (dut.u_edge_sync.rise) begin
        lat = i;
        break;
      end
      @(posedge clk_in);
    end
    check_eq("edge_latency", lat, ExpLatency);

    // Single window, period 10, with a stray start that must be ignored.
    period = 10;
    idle(20);
    one_shot("single", 10, 0, 10, 0, 40);

    // Result holds across cont toggling in idle.
    cont = 1'b1;
    idle(1);
    #1 cont = 1'b0;
    idle(5);
    @(negedge clk_in);
    check_eq("hold.count", int'(count), 10);
    check_eq("hold.busy", int'(busy), 0);

    // Static high input counts nothing.
    period    = 0;
    sig_level = 1;
    idle(10);
    one_shot("static", 0, 0, 0, 0, -1);

    // Period 4 saturates the 4-bit instance; period 20 clears its ovf.
    period = 4;
    idle(20);
    one_shot("period4", 25, 0, 15, 1, -1);
    period = 20;
    idle(30);
    one_shot("period20", 5, 0, 5, 0, -1);

    // Continuous mode: valid every 101 cycles, busy never drops.
    period = 10;
    idle(20);
    cont = 1'b1;
    @(posedge clk_in);
    #1 start = 1'b1;
    @(posedge clk_in);
    #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!valid && n < 300);
    check_eq("cont.first_valid", int'(valid), 1);
    drops = 0;
    for (int w = 0; w < 3; w++) begin
      n = 0;
      do begin
        @(negedge clk_in);
        n++;
        if (!busy) drops++;
      end while (!valid && n < 300);
      check_eq("cont.interval", n, 101);
      check_eq("cont.count", int'(count), 10);
    end
    check_eq("cont.busy_drops", drops, 0);
    cont = 1'b0;
    for (int i = 0; i < 300 && busy; i++) @(negedge clk_in);
    check_eq("cont.stop", int'(busy), 0);

    // Abort at gate cycle 50: no result, everything back to reset values.
    @(posedge clk_in);
    #1 start = 1'b1;
    @(posedge clk_in);
    #1 start = 1'b0;
    valids = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in);
      if (valid) valids++;
    end
    rst_n = 1'b0;
    #1;
    check_eq("abort.busy", int'(busy), 0);
    check_eq("abort.valid", int'(valid), 0);
    check_eq("abort.count", int'(count), 0);
    check_eq("abort.ovf", int'(ovf), 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_in);
      if (valid) valids++;
    end
    check_eq("abort.no_valid", valids, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 125000000: clk_in frequency, for documentation and bench scaling only.
REQ-002 SHALL have parameter GATE_CYCLES, default 125000: measurement window length in clk_in cycles, legal range >= 2.
REQ-003 SHALL have parameter CNT_W, default 32: width of the edge counter and of count.
REQ-004 SHALL have port clk_in  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port sig_in  input  1  signal to be measured, e.g. a divided clock.
REQ-007 SHALL have port start  input  1  single-cycle request for one measurement.
REQ-008 SHALL have port cont  input  1  continuous mode; 1 = re-arm automatically after each result.
REQ-009 SHALL have port busy  output  1  high while a measurement is in progress.
REQ-010 SHALL have port count  output  CNT_W  rising edges of sig_in counted in the last completed window.
REQ-011 SHALL have port valid  output  1  one-cycle pulse when count is updated.
REQ-012 SHALL have port ovf  output  1  last window saturated the counter.

Function
REQ-013 SHALL use FSM states IDLE, MEASURE and DONE.
REQ-014 SHALL move IDLE->MEASURE on the cycle after start=1 in IDLE, clearing the gate counter and edge counter.
REQ-015 SHALL ignore start in MEASURE or DONE.
REQ-016 SHALL, in MEASURE, increment the gate counter by 1 each cycle from 0 and go to DONE after the cycle where the gate counter = GATE_CYCLES-1, giving exactly GATE_CYCLES counting cycles.
REQ-017 SHALL increment the edge counter by 1 on each MEASURE cycle where the rising-edge pulse is high, including the final gate cycle.
REQ-018 SHALL saturate the edge counter at 2^CNT_W-1 and record overflow if an edge arrives while saturated.
REQ-019 SHALL, in DONE (exactly one cycle), load count from the edge counter, load ovf from the overflow record and assert valid for that cycle only.
REQ-020 SHALL, leaving DONE, go to MEASURE with counters cleared if cont=1, else to IDLE; edges in the DONE cycle SHALL NOT be counted.
REQ-021 SHALL hold busy=1 in MEASURE and DONE and busy=0 in IDLE.
REQ-022 SHALL hold count and ovf between DONE cycles, unaffected by start and cont.
REQ-023 SHALL NOT divide in hardware; frequency = count*CLK_HZ/GATE_CYCLES is computed by software or the bench.

Reset
REQ-024 SHALL, on rst_n=0 in any state including mid-MEASURE, go to IDLE with count=0, valid=0, busy=0, ovf=0, all counters and synchronizer flops 0.
REQ-025 SHALL accept start on the first clk_in edge after rst_n rises.

Configuration
REQ-026 SHALL use macro FREQ_METER_SYNC_EN.
REQ-027 With FREQ_METER_SYNC_EN defined, sig_in SHALL pass through a 2-flop synchronizer before edge detection, giving edge-pulse latency of 3 clk_in cycles after the sig_in rise.
REQ-028 Without FREQ_METER_SYNC_EN, sig_in SHALL be treated as synchronous to clk_in: one history flop only, edge-pulse latency of 1 cycle.

Structure
REQ-029 SHALL place the FSM state enum in a shared package freq_meter_pkg.
REQ-030 SHALL place the default GATE_CYCLES and CNT_W constants in freq_meter_pkg.
REQ-031 SHALL implement synchronizer plus rising-edge detect in sub-module edge_sync, which freq_meter instantiates once.

Verification
REQ-032 Reset: rst_n=0 while driving sig_in and start -> busy=0, valid=0, count=0, ovf=0.
REQ-033 Single measurement: GATE_CYCLES=100, sig_in period 10 cycles, start pulse -> busy high 101 cycles, one valid pulse, count=10, ovf=0.
REQ-034 Static input: sig_in held at 1, start -> count=0, valid pulses once.
REQ-035 Overflow: CNT_W=4, GATE_CYCLES=100, sig_in period 4 -> count=15, ovf=1; next window with sig_in period 20 -> count=5, ovf=0.
REQ-036 Continuous mode: cont=1, GATE_CYCLES=100, sig_in period 10 -> valid every 101 cycles, each count=10, busy never drops.
REQ-037 Abort and ignore: start pulse during MEASURE has no effect; rst_n=0 at gate cycle 50 -> IDLE, count=0, no valid pulse.
REQ-038 Both macro settings SHALL be run; edge latency SHALL be checked as 3 cycles (defined) and 1 cycle (undefined).
